// File: rtl/cpu_mon_pkg.sv
// Shared types and constants for the CPU run monitor.
// Status codes, FSM states and syscall decode.
package cpu_mon_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [1:0] STAT_NONE    = 2'b00;
  localparam logic [1:0] STAT_SYSCALL = 2'b01;
  localparam logic [1:0] STAT_LOOP    = 2'b10;
  localparam logic [1:0] STAT_TIMEOUT = 2'b11;

  localparam logic [5:0] OP_SPECIAL    = 6'h00;
  localparam logic [5:0] FUNCT_SYSCALL = 6'h0C;

  function automatic logic is_syscall(
    input logic [31:0] ins
  );
    return (ins[31:26] == OP_SPECIAL) &&
           (ins[5:0] == FUNCT_SYSCALL);
  endfunction

endpackage

// File: rtl/trace_ring_buffer.sv
// Circular (pc, instruction) trace with saturating count.
// Index 0 always names the oldest surviving entry.
module trace_ring_buffer
  import cpu_mon_pkg::*;
#(
  parameter int AW    = 32,
  parameter int DW    = 32,
  parameter int DEPTH = 16,
  parameter int IW    = $clog2(DEPTH),
  parameter int NW    = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clear,
  input  logic          we,
  input  logic [AW-1:0] wpc,
  input  logic [DW-1:0] winstr,
  input  logic [IW-1:0] rd_idx,
  output logic [NW-1:0] count,
  output logic [AW-1:0] rd_pc,
  output logic [DW-1:0] rd_instr
);

  localparam logic [NW-1:0] FULL = NW'(DEPTH);

  logic [AW+DW-1:0] mem [DEPTH];
  logic [IW-1:0]    wr_ptr;
  logic [IW-1:0]    phys;
  logic             full;
  logic             hit;

  assign full = (count == FULL);
  assign phys = full ? wr_ptr + rd_idx : rd_idx;
  assign hit  = ({1'b0, rd_idx} < count);

  // storage write; contents are meaningless until counted
  always_ff @(posedge clk) begin
    if (we) mem[wr_ptr] <= {wpc, winstr};
  end

  // write pointer and saturating entry count
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      count  <= '0;
    end else if (we) begin
      wr_ptr <= wr_ptr + 1'b1;
      if (!full) count <= count + 1'b1;
    end
  end

  // registered read; sees pre-write contents on a same-edge write
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      {rd_pc, rd_instr} <= '0;
    end else if (hit) begin
      {rd_pc, rd_instr} <= mem[phys];
    end else begin
      {rd_pc, rd_instr} <= '0;
    end
  end

endmodule

// File: rtl/cpu_run_monitor.sv
// Run-control monitor: ends a run on syscall, loop/halt-pc
// or timeout, and keeps a trace of the last DEPTH samples.
module cpu_run_monitor
  import cpu_mon_pkg::*;
#(
  parameter int AW          = 32,
  parameter int DW          = 32,
  parameter int DEPTH       = 16,
  parameter int LOOP_THRESH = 4,
  parameter int MAX_CYCLES  = 4096,
  parameter int CW          = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic [AW-1:0]            pc,
  input  logic [DW-1:0]            instruction,
  input  logic [AW-1:0]            halt_pc,
  input  logic                     halt_pc_en,
  output logic                     done,
  output logic [1:0]               status,
  output logic [CW-1:0]            cycle_count,
  output logic [$clog2(DEPTH):0]   trace_count,
  input  logic [$clog2(DEPTH)-1:0] trace_rd_idx,
  output logic [AW-1:0]            trace_rd_pc,
  output logic [DW-1:0]            trace_rd_instr
);

  localparam int LW = $clog2(LOOP_THRESH + 1);

  state_t        state;
  logic [LW-1:0] loop_cnt;
  logic [LW-1:0] loop_nxt;
  logic [AW-1:0] prev_pc;
  logic [CW-1:0] cyc_nxt;
  logic          sys_hit;
  logic          loop_hit;
  logic          tmo_hit;
  logic          term;
  logic [1:0]    term_stat;
  logic          running;
  logic          arm;

  assign running = (state == RUN);
  assign arm     = !running && start;

  // termination decode on the current sample
  always_comb begin
    loop_nxt  = (pc == prev_pc) ? loop_cnt + 1'b1 : '0;
    cyc_nxt   = cycle_count + 1'b1;
    sys_hit   = is_syscall(instruction[31:0]);
    loop_hit  = (loop_nxt == LW'(LOOP_THRESH)) ||
                (halt_pc_en && (pc == halt_pc));
    tmo_hit   = (cyc_nxt == CW'(MAX_CYCLES));
    term      = sys_hit || loop_hit || tmo_hit;
    term_stat = STAT_NONE;
    if (sys_hit)       term_stat = STAT_SYSCALL;
    else if (loop_hit) term_stat = STAT_LOOP;
    else if (tmo_hit)  term_stat = STAT_TIMEOUT;
  end

  // run FSM with counters and registered done/status
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      done        <= 1'b0;
      status      <= STAT_NONE;
      cycle_count <= '0;
      loop_cnt    <= '0;
      prev_pc     <= '0;
    end else begin
      case (state)
        RUN: begin
          cycle_count <= cyc_nxt;
          loop_cnt    <= loop_nxt;
          prev_pc     <= pc;
          if (term) begin
            state  <= DONE;
            done   <= 1'b1;
            status <= term_stat;
          end
        end
        default: begin
          if (start) begin
            state       <= RUN;
            done        <= 1'b0;
            status      <= STAT_NONE;
            cycle_count <= '0;
            loop_cnt    <= '0;
            prev_pc     <= '0;
          end
        end
      endcase
    end
  end

  trace_ring_buffer #(
    .AW    (AW),
    .DW    (DW),
    .DEPTH (DEPTH)
  ) u_trace (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear    (arm),
    .we       (running),
    .wpc      (pc),
    .winstr   (instruction),
    .rd_idx   (trace_rd_idx),
    .count    (trace_count),
    .rd_pc    (trace_rd_pc),
    .rd_instr (trace_rd_instr)
  );

endmodule

// File: tb/tb_cpu_run_monitor.sv
// Directed bench for cpu_run_monitor.
// Two instances: short watchdog (a) and long watchdog (b).
module tb_cpu_run_monitor;

  localparam logic [31:0] NOP = 32'h2000_0000;
  localparam logic [31:0] SYS = 32'h0000_000C;
  localparam logic [31:0] JMP = 32'h0800_0007;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start_a = 1'b0;
  logic        start_b = 1'b0;
  logic [31:0] pc = '0;
  logic [31:0] instruction = NOP;
  logic [31:0] halt_pc = '0;
  logic        halt_pc_en = 1'b0;
  logic [2:0]  rd_idx = '0;

  logic        done_a, done_b;
  logic [1:0]  status_a, status_b;
  logic [31:0] cyc_a, cyc_b;
  logic [3:0]  tcnt_a, tcnt_b;
  logic [31:0] rpc_a, rpc_b;
  logic [31:0] rins_a, rins_b;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  cpu_run_monitor #(
    .AW(32), .DW(32), .DEPTH(8),
    .LOOP_THRESH(4), .MAX_CYCLES(16), .CW(32)
  ) u_a (
    .clk(clk), .rst_n(rst_n), .start(start_a),
    .pc(pc), .instruction(instruction),
    .halt_pc(halt_pc), .halt_pc_en(halt_pc_en),
    .done(done_a), .status(status_a),
    .cycle_count(cyc_a), .trace_count(tcnt_a),
    .trace_rd_idx(rd_idx),
    .trace_rd_pc(rpc_a), .trace_rd_instr(rins_a)
  );

  cpu_run_monitor #(
    .AW(32), .DW(32), .DEPTH(8),
    .LOOP_THRESH(4), .MAX_CYCLES(4096), .CW(32)
  ) u_b (
    .clk(clk), .rst_n(rst_n), .start(start_b),
    .pc(pc), .instruction(instruction),
    .halt_pc(halt_pc), .halt_pc_en(halt_pc_en),
    .done(done_b), .status(status_b),
    .cycle_count(cyc_b), .trace_count(tcnt_b),
    .trace_rd_idx(rd_idx),
    .trace_rd_pc(rpc_b), .trace_rd_instr(rins_b)
  );

  task automatic check(
    input string       tag,
    input logic [63:0] got,
    input logic [63:0] exp
  );
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h",
               tag, got, exp);
    end
  endtask

  // present one sample, return at the following negedge
  task automatic drive(
    input logic [31:0] p,
    input logic [31:0] i
  );
    pc = p;
    instruction = i;
    @(negedge clk);
  endtask

  task automatic arm_a();
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
  endtask

  task automatic arm_b();
    start_b = 1'b1;
    @(negedge clk);
    start_b = 1'b0;
  endtask

  initial begin
    repeat (2) @(negedge clk);
    check("rst_done", done_a, 0);
    check("rst_status", status_a, 0);
    check("rst_cycles", cyc_a, 0);
    check("rst_tcount", tcnt_a, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // 1: async reset mid-run
    arm_a();
    for (int k = 0; k < 5; k++)
      drive(32'h100 + 32'(k * 4), NOP);
    check("t1_precycles", cyc_a, 5);
    #2 rst_n = 1'b0;
    #1;
    check("t1_done", done_a, 0);
    check("t1_status", status_a, 0);
    check("t1_cycles", cyc_a, 0);
    check("t1_tcount", tcnt_a, 0);
    #1 rst_n = 1'b1;
    @(negedge clk);

    // 2: syscall stop
    arm_a();
    drive(32'h0, NOP);
    drive(32'h4, NOP);
    check("t2_notdone", done_a, 0);
    drive(32'h8, SYS);
    check("t2_done", done_a, 1);
    check("t2_status", status_a, 1);
    check("t2_cycles", cyc_a, 3);
    check("t2_tcount", tcnt_a, 3);
    rd_idx = 3'd2;
    @(negedge clk);
    check("t2_idx2_pc", rpc_a, 32'h8);
    check("t2_idx2_ins", rins_a, SYS);
    rd_idx = 3'd5;
    @(negedge clk);
    check("t2_idx5_empty", rpc_a, 0);
    check("t2_frozen", cyc_a, 3);

    // 3a: self-loop stop
    arm_a();
    drive(32'h18, JMP);
    for (int k = 0; k < 4; k++) drive(32'h1C, JMP);
    check("t3_notdone", done_a, 0);
    drive(32'h1C, JMP);
    check("t3_done", done_a, 1);
    check("t3_status", status_a, 2);
    check("t3_cycles", cyc_a, 6);

    // 3b: halt_pc stop
    halt_pc = 32'h10;
    halt_pc_en = 1'b1;
    arm_a();
    drive(32'h8, NOP);
    drive(32'hC, NOP);
    check("t3h_notdone", done_a, 0);
    drive(32'h10, NOP);
    check("t3h_done", done_a, 1);
    check("t3h_status", status_a, 2);
    check("t3h_cycles", cyc_a, 3);
    halt_pc_en = 1'b0;

    // 4: timeout
    arm_a();
    for (int k = 0; k < 15; k++)
      drive(32'h100 + 32'(k * 4), NOP);
    check("t4_notdone15", done_a, 0);
    drive(32'h13C, NOP);
    check("t4_done", done_a, 1);
    check("t4_status", status_a, 3);
    check("t4_cycles", cyc_a, 16);
    check("t4_tcount", tcnt_a, 8);

    // 6: syscall outranks timeout, then restart from DONE
    arm_a();
    for (int k = 0; k < 15; k++)
      drive(32'h100 + 32'(k * 4), NOP);
    drive(32'h13C, SYS);
    check("t6_done", done_a, 1);
    check("t6_status", status_a, 1);
    check("t6_cycles", cyc_a, 16);
    pc = 32'h200;
    instruction = NOP;
    arm_a();
    check("t6r_done", done_a, 0);
    check("t6r_status", status_a, 0);
    check("t6r_cycles", cyc_a, 0);
    check("t6r_tcount", tcnt_a, 0);
    drive(32'h200, NOP);
    drive(32'h204, SYS);
    check("t6r_done2", done_a, 1);
    check("t6r_status2", status_a, 1);
    check("t6r_cycles2", cyc_a, 2);
    rd_idx = 3'd0;
    @(negedge clk);
    check("t6r_idx0_pc", rpc_a, 32'h200);

    // 5: wrap-around on the long-watchdog instance
    arm_b();
    for (int k = 0; k < 20; k++)
      drive(32'(k * 4), NOP);
    check("t5_notdone", done_b, 0);
    drive(32'h50, SYS);
    check("t5_done", done_b, 1);
    check("t5_status", status_b, 1);
    check("t5_cycles", cyc_b, 21);
    check("t5_tcount", tcnt_b, 8);
    rd_idx = 3'd0;
    @(negedge clk);
    check("t5_idx0_pc", rpc_b, 32'h34);
    rd_idx = 3'd3;
    @(negedge clk);
    check("t5_idx3_pc", rpc_b, 32'h40);
    rd_idx = 3'd7;
    @(negedge clk);
    check("t5_idx7_pc", rpc_b, 32'h50);
    check("t5_idx7_ins", rins_b, SYS);

    $display("[TB] %0d tests run, %0d failed",
             n_tests, n_fail);
    $finish;
  end

endmodule
